// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

   localparam int DATA_BITS = 8;

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;

   // Sample-tick divider rounded to the nearest integer.
   function automatic int calc_div(input int clock, input int baud, input int os);
      return (clock + (baud * os) / 2) / (baud * os);
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Oversample tick generator: one-cycle tick every calc_div(CLOCK_RATE, BAUD_RATE, OVERSAMPLE) clocks.
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int CLOCK_RATE = 50_000_000,
   parameter int BAUD_RATE  = 9_600,
   parameter int OVERSAMPLE = 16
) (
   input  logic clk_rx,
   input  logic rst_clk_rx,
   output logic tick
);

   localparam int DIV = calc_div(CLOCK_RATE, BAUD_RATE, OVERSAMPLE);
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CNT_LAST) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk_rx or posedge rst_clk_rx) begin
      if (rst_clk_rx) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_rx_core.sv
// RS232 8N1 receiver; byte valid ~9.5 bit times + 3 clocks after the start edge, held until rx_ack.
// A byte completing while the holding register is full is dropped with an overrun pulse. UART_RX_VOTE_EN: 2-of-3 sample vote.
module uart_rx_core
   import uart_pkg::*;
#(
   parameter int CLOCK_RATE = 50_000_000,
   parameter int BAUD_RATE  = 9_600,
   parameter int OVERSAMPLE = 16
) (
   input  logic                 clk_rx,
   input  logic                 rst_clk_rx,
   input  logic                 rxd_i,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ack,
   output logic                 frm_err,
   output logic                 overrun
);

   localparam int MID  = OVERSAMPLE / 2 - 1;
   localparam int SCW  = $clog2(OVERSAMPLE);
   localparam int IDXW = $clog2(DATA_BITS);
`ifdef UART_RX_VOTE_EN
   localparam int DEC_SC = MID + 1;
`else
   localparam int DEC_SC = MID;
`endif
   localparam logic [SCW-1:0]  SC_DEC   = SCW'(DEC_SC);
   localparam logic [SCW-1:0]  SC_LAST  = SCW'(OVERSAMPLE - 1);
   localparam logic [IDXW-1:0] IDX_LAST = IDXW'(DATA_BITS - 1);

   logic                 tick;
   logic                 sync1_q, sync2_q;
   logic                 rxd_s;
   logic                 bit_smp;
   rx_state_t            state_q, state_d;
   logic [SCW-1:0]       sc_q, sc_d;
   logic [IDXW-1:0]      idx_q, idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 push_q, push_d;
   logic                 frm_q, frm_d;
   logic                 valid_q, valid_d;
   logic                 ovr_q, ovr_d;

   uart_baud_gen #(
      .CLOCK_RATE (CLOCK_RATE),
      .BAUD_RATE  (BAUD_RATE),
      .OVERSAMPLE (OVERSAMPLE)
   ) u_baud_gen (
      .clk_rx     (clk_rx),
      .rst_clk_rx (rst_clk_rx),
      .tick       (tick)
   );

   assign rxd_s = sync2_q;

`ifdef UART_RX_VOTE_EN
   // hist_q holds the samples from the two previous ticks (MID-1, MID when sc=MID+1).
   logic [1:0] hist_q;

   always_ff @(posedge clk_rx or posedge rst_clk_rx) begin
      if (rst_clk_rx) begin
         hist_q <= 2'b11;
      end else if (tick) begin
         hist_q <= {hist_q[0], rxd_s};
      end
   end

   assign bit_smp = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxd_s) | (hist_q[0] & rxd_s);
`else
   assign bit_smp = rxd_s;
`endif

   // The start bit runs its full cell length so every later bit is sampled mid-cell.
   always_comb begin
      state_d = state_q;
      sc_d    = sc_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      push_d  = 1'b0;
      frm_d   = 1'b0;
      if (tick) begin
         case (state_q)
            IDLE: begin
               if (!rxd_s) begin
                  state_d = START;
                  sc_d    = '0;
               end
            end
            START: begin
               sc_d = sc_q + SCW'(1);
               if (sc_q == SC_DEC && bit_smp) begin
                  state_d = IDLE;
                  sc_d    = '0;
               end else if (sc_q == SC_LAST) begin
                  state_d = DATA;
                  sc_d    = '0;
                  idx_d   = '0;
               end
            end
            DATA: begin
               sc_d = sc_q + SCW'(1);
               if (sc_q == SC_DEC) begin
                  shift_d = {bit_smp, shift_q[DATA_BITS-1:1]};
               end
               if (sc_q == SC_LAST) begin
                  sc_d  = '0;
                  idx_d = idx_q + IDXW'(1);
                  if (idx_q == IDX_LAST) begin
                     state_d = STOP;
                  end
               end
            end
            STOP: begin
               sc_d = sc_q + SCW'(1);
               if (sc_q == SC_DEC) begin
                  sc_d = '0;
                  if (bit_smp) begin
                     push_d  = 1'b1;
                     state_d = IDLE;
                  end else begin
                     frm_d   = 1'b1;
                     state_d = BREAK;
                  end
               end
            end
            BREAK: begin
               if (rxd_s) begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      ovr_d   = 1'b0;
      if (push_q) begin
         if (!valid_q || rx_ack) begin
            data_d  = shift_q;
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end else if (rx_ack) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_rx or posedge rst_clk_rx) begin
      if (rst_clk_rx) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         state_q <= IDLE;
         sc_q    <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         push_q  <= 1'b0;
         frm_q   <= 1'b0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         sync1_q <= rxd_i;
         sync2_q <= sync1_q;
         state_q <= state_d;
         sc_q    <= sc_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         push_q  <= push_d;
         frm_q   <= frm_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
      end
   end

   assign rx_data  = data_q;
   assign rx_valid = valid_q;
   assign frm_err  = frm_q;
   assign overrun  = ovr_q;

endmodule
